// File: rtl/vc_elastic_pipe_reg.sv
// Elastic val/rdy pipeline register chain of p_nstages stages. Each stage is either a
// single-entry pipe register or a two-entry skid buffer whose upstream ready is a flop.
module vc_elastic_pipe_reg #(
  parameter int p_nbits       = 32,
  parameter int p_nstages     = 2,
  parameter int p_reset_value = 0,
  parameter int p_skid        = 1,
  localparam int Cap  = p_nstages * (p_skid + 1),
  localparam int OccW = $clog2(Cap + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_msg,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg,
  output logic [OccW-1:0]    occupancy
);

  localparam logic [p_nbits-1:0] ResetMsg = p_nbits'(p_reset_value);

  logic               stage0Rdy;
  logic               headVal;
  logic [p_nbits-1:0] headMsg;
  logic               inXfer;
  logic               outXfer;
  logic [OccW-1:0]    occ_q;
  logic [OccW-1:0]    occ_d;

  // Both handshakes are forced idle while reset is high, so nothing moves on a reset cycle.
  assign in_rdy    = stage0Rdy && !reset;
  assign out_val   = headVal && !reset;
  assign out_msg   = headMsg;
  assign inXfer    = in_val && in_rdy;
  assign outXfer   = out_val && out_rdy;
  assign occupancy = occ_q;

  always_comb begin
    occ_d = occ_q;
    if (inXfer && !outXfer) begin
      occ_d = occ_q + OccW'(1);
    end else if (!inXfer && outXfer) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  if (p_skid != 0) begin : g_skid
    logic [p_nstages-1:0] mainVal_q;
    logic [p_nstages-1:0] mainVal_d;
    logic [p_nstages-1:0] skidVal_q;
    logic [p_nstages-1:0] skidVal_d;
    logic [p_nbits-1:0]   mainMsg_q [p_nstages];
    logic [p_nbits-1:0]   mainMsg_d [p_nstages];
    logic [p_nbits-1:0]   skidMsg_q [p_nstages];
    logic [p_nbits-1:0]   skidMsg_d [p_nstages];
    logic [p_nstages-1:0] offVal;
    logic [p_nstages-1:0] dnRdy;
    logic [p_nstages-1:0] acc;
    logic [p_nstages-1:0] pop;
    logic [p_nbits-1:0]   offMsg [p_nstages];

    // A stage only looks at its neighbours' registered state, so ready never ripples.
    always_comb begin
      mainVal_d = mainVal_q;
      skidVal_d = skidVal_q;
      mainMsg_d = mainMsg_q;
      skidMsg_d = skidMsg_q;
      offMsg    = mainMsg_q;
      offVal    = '0;
      dnRdy     = '0;
      acc       = '0;
      pop       = '0;
      for (int k = 0; k < p_nstages; k++) begin
        if (k == 0) begin
          offVal[k] = in_val;
          offMsg[k] = in_msg;
        end else begin
          offVal[k] = mainVal_q[k-1];
          offMsg[k] = mainMsg_q[k-1];
        end
        if (k == p_nstages - 1) begin
          dnRdy[k] = out_rdy;
        end else begin
          dnRdy[k] = !skidVal_q[k+1];
        end
        acc[k] = offVal[k] && !skidVal_q[k];
        pop[k] = mainVal_q[k] && dnRdy[k];

        if (pop[k]) begin
          if (skidVal_q[k]) begin
            mainMsg_d[k] = skidMsg_q[k];
            skidVal_d[k] = 1'b0;
          end else if (acc[k]) begin
            mainMsg_d[k] = offMsg[k];
          end else begin
            mainVal_d[k] = 1'b0;
          end
        end else if (acc[k]) begin
          if (!mainVal_q[k]) begin
            mainVal_d[k] = 1'b1;
            mainMsg_d[k] = offMsg[k];
          end else begin
            skidVal_d[k] = 1'b1;
            skidMsg_d[k] = offMsg[k];
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        mainVal_q <= '0;
        skidVal_q <= '0;
        for (int k = 0; k < p_nstages; k++) begin
          mainMsg_q[k] <= ResetMsg;
          skidMsg_q[k] <= ResetMsg;
        end
      end else begin
        mainVal_q <= mainVal_d;
        skidVal_q <= skidVal_d;
        mainMsg_q <= mainMsg_d;
        skidMsg_q <= skidMsg_d;
      end
    end

    assign stage0Rdy = !skidVal_q[0];
    assign headVal   = mainVal_q[p_nstages-1];
    assign headMsg   = mainMsg_q[p_nstages-1];
  end else begin : g_pipe
    logic [p_nstages-1:0] val_q;
    logic [p_nstages-1:0] val_d;
    logic [p_nstages-1:0] adv;
    logic [p_nstages-1:0] offVal;
    logic [p_nbits-1:0]   msg_q  [p_nstages];
    logic [p_nbits-1:0]   msg_d  [p_nstages];
    logic [p_nbits-1:0]   offMsg [p_nstages];

    // Ready ripples back from out_rdy, so the chain is walked head-first.
    always_comb begin
      val_d  = val_q;
      msg_d  = msg_q;
      offMsg = msg_q;
      offVal = '0;
      adv    = '0;
      for (int k = p_nstages - 1; k >= 0; k--) begin
        if (k == p_nstages - 1) begin
          adv[k] = !val_q[k] || out_rdy;
        end else begin
          adv[k] = !val_q[k] || adv[k+1];
        end
        if (k == 0) begin
          offVal[k] = in_val;
          offMsg[k] = in_msg;
        end else begin
          offVal[k] = val_q[k-1];
          offMsg[k] = msg_q[k-1];
        end
        if (adv[k]) begin
          val_d[k] = offVal[k];
          if (offVal[k]) begin
            msg_d[k] = offMsg[k];
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        val_q <= '0;
        for (int k = 0; k < p_nstages; k++) begin
          msg_q[k] <= ResetMsg;
        end
      end else begin
        val_q <= val_d;
        msg_q <= msg_d;
      end
    end

    assign stage0Rdy = adv[0];
    assign headVal   = val_q[p_nstages-1];
    assign headMsg   = msg_q[p_nstages-1];
  end

  // Protocol inputs must be known once out of reset, and the count can never pass capacity.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown(in_val) && !$isunknown(out_rdy));
      assert (occ_q <= OccW'(Cap));
    end
  end

endmodule

// File: tb/tb_vc_elastic_pipe_reg.sv
// Bench for vc_elastic_pipe_reg: a skid instance and a combinational-ready instance share
// stimulus; each has its own queue-based reference and a negedge monitor.
module tb_vc_elastic_pipe_reg;

  localparam int W    = 32;
  localparam int N    = 2;
  localparam int CapS = 2 * N;
  localparam int CapC = N;
  localparam logic [W-1:0] RstVal = 32'h1234_5678;

  typedef struct packed {
    logic [W-1:0] msg;
    int unsigned  cyc;
  } entry_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         inVal;
  logic [W-1:0] inMsg;
  logic         outRdy;

  logic         inRdyS, outValS, inRdyC, outValC;
  logic [W-1:0] outMsgS, outMsgC;
  logic [2:0]   occS;
  logic [1:0]   occC;

  entry_t       qS[$];
  entry_t       qC[$];
  int           vectors = 0;
  int           miscompares = 0;
  int unsigned  cyc = 0;
  logic         prevReset = 1'b0;
  logic         prevHold [2];
  logic [W-1:0] prevMsgH [2];
  logic         freeFlow = 1'b0;

  always #5 clk = ~clk;

  vc_elastic_pipe_reg #(
    .p_nbits(W), .p_nstages(N), .p_reset_value(int'(RstVal)), .p_skid(1)
  ) dutSkid (
    .clk(clk), .reset(reset),
    .in_val(inVal), .in_rdy(inRdyS), .in_msg(inMsg),
    .out_val(outValS), .out_rdy(outRdy), .out_msg(outMsgS),
    .occupancy(occS)
  );

  vc_elastic_pipe_reg #(
    .p_nbits(W), .p_nstages(N), .p_reset_value(int'(RstVal)), .p_skid(0)
  ) dutComb (
    .clk(clk), .reset(reset),
    .in_val(inVal), .in_rdy(inRdyC), .in_msg(inMsg),
    .out_val(outValC), .out_rdy(outRdy), .out_msg(outMsgC),
    .occupancy(occC)
  );

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int qSize(input int i);
    return (i == 0) ? qS.size() : qC.size();
  endfunction

  function automatic void qPush(input int i, input entry_t e);
    if (i == 0) qS.push_back(e);
    else qC.push_back(e);
  endfunction

  function automatic entry_t qPop(input int i);
    if (i == 0) return qS.pop_front();
    return qC.pop_front();
  endfunction

  function automatic void qClear(input int i);
    if (i == 0) qS.delete();
    else qC.delete();
  endfunction

  // Reference for one instance: a FIFO of accepted messages; its size is the expected occupancy.
  task automatic monitorOne(input int i, input logic ir, input logic ov, input logic [W-1:0] om,
                            input int occ, input int cap);
    entry_t e;
    if (reset) begin
      checkOutput("reset_in_rdy", ir, 1'b0);
      checkOutput("reset_out_val", ov, 1'b0);
      qClear(i);
      prevHold[i] = 1'b0;
      return;
    end
    if (prevReset) begin
      checkOutput("post_reset_out_msg", om, RstVal);
      checkOutput("post_reset_in_rdy", ir, 1'b1);
    end
    checkOutput("occupancy", occ, qSize(i));
    if (qSize(i) == 0) begin
      checkOutput("empty_out_val", ov, 1'b0);
      checkOutput("empty_in_rdy", ir, 1'b1);
    end
    if (occ == cap) begin
      checkOutput("full_in_rdy", ir, (i == 0) ? 1'b0 : outRdy);
    end
    if (prevHold[i]) begin
      checkOutput("stall_out_val", ov, 1'b1);
      checkOutput("stall_out_msg", om, prevMsgH[i]);
    end
    if (freeFlow) begin
      checkOutput("flow_in_rdy", ir, 1'b1);
    end
    if (ov && outRdy) begin
      if (qSize(i) == 0) begin
        checkOutput("spurious_out_val", ov, 1'b0);
      end else begin
        e = qPop(i);
        checkOutput("out_msg", om, e.msg);
        if (freeFlow) checkOutput("latency", cyc - e.cyc, N);
      end
    end
    prevHold[i] = ov && !outRdy;
    prevMsgH[i] = om;
    if (inVal && ir) begin
      e.msg = inMsg;
      e.cyc = cyc;
      qPush(i, e);
    end
  endtask

  always @(negedge clk) begin
    monitorOne(0, inRdyS, outValS, outMsgS, int'(occS), CapS);
    monitorOne(1, inRdyC, outValC, outMsgC, int'(occC), CapC);
    prevReset = reset;
    cyc++;
  end

  task automatic applyStimulus(input logic v, input logic [W-1:0] m, input logic r);
    inVal  = v;
    inMsg  = m;
    outRdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drainAll(input int limit);
    int n = 0;
    while ((qS.size() != 0 || qC.size() != 0) && n < limit) begin
      applyStimulus(1'b0, '0, 1'b1);
      n++;
    end
    checkOutput("drain_left_skid", qS.size(), 0);
    checkOutput("drain_left_comb", qC.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    prevHold[0] = 1'b0;
    prevHold[1] = 1'b0;
    prevMsgH[0] = '0;
    prevMsgH[1] = '0;
    reset  = 1'b1;
    inVal  = 1'b1;
    inMsg  = 32'hA5;
    outRdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Free-flowing stream: 0xA5 then 0..99, every message N cycles after acceptance.
    $display("[TB] stream with out_rdy held high");
    freeFlow = 1'b1;
    applyStimulus(1'b1, 32'hA5, 1'b1);
    for (int k = 0; k < 100; k++) applyStimulus(1'b1, W'(k), 1'b1);
    drainAll(20);
    freeFlow = 1'b0;

    // Stall until both instances are full, then release.
    $display("[TB] fill under back-pressure");
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, $urandom(), 1'b0);
    checkOutput("full_occ_skid", occS, CapS);
    checkOutput("full_occ_comb", occC, CapC);
    checkOutput("full_in_rdy_skid", inRdyS, 1'b0);
    checkOutput("full_in_rdy_comb", inRdyC, 1'b0);
    checkOutput("full_out_val_skid", outValS, 1'b1);
    checkOutput("full_head_skid", outMsgS, qS[0].msg);
    checkOutput("full_head_comb", outMsgC, qC[0].msg);
    drainAll(30);

    // Reset with messages held: they must vanish and outputs return to reset values.
    $display("[TB] reset while holding messages");
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 32'hC0DE_0000 + W'(k), 1'b0);
    checkOutput("held_occ_skid", occS, 3);
    reset = 1'b1;
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1);
    reset = 1'b0;
    checkOutput("after_reset_occ_skid", occS, 0);
    checkOutput("after_reset_occ_comb", occC, 0);
    checkOutput("after_reset_val_skid", outValS, 1'b0);
    checkOutput("after_reset_val_comb", outValC, 1'b0);
    checkOutput("after_reset_msg_skid", outMsgS, RstVal);
    checkOutput("after_reset_msg_comb", outMsgC, RstVal);
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 32'h5000 + W'(k), 1'b1);
    drainAll(20);

    // Skid ready must not follow out_rdy within a cycle; comb ready must.
    $display("[TB] toggle out_rdy mid-cycle while full");
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, $urandom(), 1'b0);
    for (int k = 0; k < 6; k++) begin
      inVal = 1'b1;
      inMsg = $urandom();
      #1 outRdy = 1'b1;
      #1 checkOutput("skid_rdy_no_comb_hi", inRdyS, 1'b0);
      checkOutput("comb_rdy_follows_hi", inRdyC, 1'b1);
      outRdy = 1'b0;
      #1 checkOutput("skid_rdy_no_comb_lo", inRdyS, 1'b0);
      checkOutput("comb_rdy_follows_lo", inRdyC, 1'b0);
      @(posedge clk);
      #1;
    end
    drainAll(30);

    // Random traffic in phases of differing pressure, with occasional resets.
    $display("[TB] random traffic");
    for (int p = 0; p < 8; p++) begin
      int pv = $urandom_range(1, 9);
      int pr = $urandom_range(1, 9);
      for (int k = 0; k < 500; k++) begin
        reset = ($urandom_range(0, 499) == 0);
        applyStimulus($urandom_range(0, 9) < pv, $urandom(), $urandom_range(0, 9) < pr);
        reset = 1'b0;
      end
    end
    drainAll(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
